apu_fu_issue_ctrl: RTL and testbench

- Initiator-side controller that drives a pipelined, non-stallable APU functional unit (fp mult/add class) and collects its results.
- Accepts operations from a core-side request port (req/gnt), issues them to the unit's En/Op/Tag/Rnd inputs, and captures every Valid/Res/Tag/Status return into a result FIFO.
- The unit cannot be back-pressured once it has accepted an operation. A credit scheme therefore guarantees that FIFO space exists for every operation in flight.
- Sits between the core-side APU interconnect port and one functional-unit wrapper.

---
 rtl/apu_cluster_package.sv | 32 +++
 rtl/apu_res_fifo.sv | 82 ++++++++
 rtl/apu_fu_issue_ctrl.sv | 132 +++++++++++++
 tb/tb_apu_fu_issue_ctrl.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apu_cluster_package.sv
// ---------------------------------------------------------------------------
// apu_cluster_package
// Shared widths and types for the APU cluster: floating-point operand width,
// downstream (rounding-mode) and upstream (status) flag widths, the default
// tag width and the result-entry layout held in the result FIFOs.
// Also provides helpers for sizing counters and pointers from a depth.
// ---------------------------------------------------------------------------
package apu_cluster_package;

  localparam int unsigned FP_WIDTH      = 32;
  localparam int unsigned NDSFLAGS      = 3;  // flags sent to a unit (rounding mode)
  localparam int unsigned NUSFLAGS      = 5;  // flags returned by a unit (status)
  localparam int unsigned APU_TAG_WIDTH = 5;

  // One returned result as it sits in a result FIFO.
  typedef struct packed {
    logic [FP_WIDTH-1:0]      res;
    logic [APU_TAG_WIDTH-1:0] tag;
    logic [NUSFLAGS-1:0]      status;
  } apu_res_entry_t;

  // Width able to hold values 0..depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // Width able to address depth entries; at least one bit.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/apu_res_fifo.sv
// ---------------------------------------------------------------------------
// apu_res_fifo
// Synchronous result FIFO with occupancy count and overflow indication.
// Pointers wrap modulo DEPTH, so non-power-of-two depths are supported.
// The head entry is shown combinationally and reads as 0 when empty.
//
// Ports:
//   clk_i       clock
//   rst_ni      asynchronous active-low reset
//   push_i      write data_i at the tail
//   data_i      entry to write
//   pop_i       remove the head entry (ignored when empty)
//   data_o      head entry, 0 when empty
//   count_o     number of entries held
//   overflow_o  push while full without a same-cycle pop; the write is dropped
// ---------------------------------------------------------------------------
module apu_res_fifo
  import apu_cluster_package::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 42,
  localparam int unsigned CNT_W = cnt_width(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic [CNT_W-1:0] count_o,
  output logic             overflow_o
);

  localparam int unsigned PTR_W = ptr_width(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == CNT_W'(DEPTH));
  assign w_pop      = pop_i & ~w_empty;
  // A pop frees the head slot in the same cycle, so a full FIFO can still
  // accept a write when it is also being read.
  assign w_push     = push_i & (~w_full | w_pop);
  assign overflow_o = push_i & w_full & ~w_pop;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= ptr_inc(r_wptr);
      if (w_pop)  r_rptr <= ptr_inc(r_rptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: the count gates everything that reads it.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr] <= data_i;
  end

  assign data_o  = w_empty ? '0 : r_mem[r_rptr];
  assign count_o = r_count;

endmodule

// File: rtl/apu_fu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// apu_fu_issue_ctrl
// Issues core requests to a pipelined, non-stallable APU functional unit and
// buffers its returns. Because the unit cannot be stalled, an operation is
// only granted when the result FIFO is guaranteed to have room for it:
// (in flight + buffered) < RES_FIFO_DEPTH, from registered state only.
//
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   req_i/gnt_o                   core request handshake
//   opa_i, opb_i, tag_i, rnd_i    request payload
//   fu_en_o, fu_opa_o, fu_opb_o,
//   fu_tag_o, fu_rnd_o            issue port to the unit
//   fu_ready_i                    unit can accept an operation
//   fu_valid_i, fu_res_i,
//   fu_tag_i, fu_status_i         unit return port
//   rvalid_o, rdata_o, rtag_o,
//   rstatus_o, rack_i             buffered result port to the core
//   busy_o                        work in flight or buffered
//   err_o                         sticky protocol-violation flag
// ---------------------------------------------------------------------------
module apu_fu_issue_ctrl
  import apu_cluster_package::*;
#(
  parameter int unsigned OP_WIDTH       = FP_WIDTH,
  parameter int unsigned TAG_WIDTH      = APU_TAG_WIDTH,
  parameter int unsigned RND_WIDTH      = NDSFLAGS,
  parameter int unsigned STAT_WIDTH     = NUSFLAGS,
  parameter int unsigned RES_FIFO_DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_i,
  output logic                  gnt_o,
  input  logic [OP_WIDTH-1:0]   opa_i,
  input  logic [OP_WIDTH-1:0]   opb_i,
  input  logic [TAG_WIDTH-1:0]  tag_i,
  input  logic [RND_WIDTH-1:0]  rnd_i,
  output logic                  fu_en_o,
  output logic [OP_WIDTH-1:0]   fu_opa_o,
  output logic [OP_WIDTH-1:0]   fu_opb_o,
  output logic [TAG_WIDTH-1:0]  fu_tag_o,
  output logic [RND_WIDTH-1:0]  fu_rnd_o,
  input  logic                  fu_ready_i,
  input  logic                  fu_valid_i,
  input  logic [OP_WIDTH-1:0]   fu_res_i,
  input  logic [TAG_WIDTH-1:0]  fu_tag_i,
  input  logic [STAT_WIDTH-1:0] fu_status_i,
  output logic                  rvalid_o,
  output logic [OP_WIDTH-1:0]   rdata_o,
  output logic [TAG_WIDTH-1:0]  rtag_o,
  output logic [STAT_WIDTH-1:0] rstatus_o,
  input  logic                  rack_i,
  output logic                  busy_o,
  output logic                  err_o
);

  localparam int unsigned CNT_W = cnt_width(RES_FIFO_DEPTH);
  localparam int unsigned ENT_W = OP_WIDTH + TAG_WIDTH + STAT_WIDTH;

  logic [CNT_W-1:0] r_outstanding;
  logic             r_err;

  logic [CNT_W-1:0] w_count;
  logic [CNT_W:0]   w_committed;
  logic             w_credit_ok;
  logic             w_gnt;
  logic             w_rvalid;
  logic             w_pop;
  logic             w_overflow;
  logic             w_stray_ret;
  logic [ENT_W-1:0] w_head;

  // Credit is taken from registered counts only; a pop in this cycle frees
  // its slot for the next cycle, keeping rack_i off the gnt_o path.
  assign w_committed = {1'b0, r_outstanding} + {1'b0, w_count};
  assign w_credit_ok = (w_committed < (CNT_W + 1)'(RES_FIFO_DEPTH));

  assign w_gnt    = req_i & fu_ready_i & w_credit_ok;
  assign gnt_o    = w_gnt;
  assign fu_en_o  = w_gnt;
  // Operands are isolated so the unit's datapath does not toggle when idle.
  assign fu_opa_o = w_gnt ? opa_i : '0;
  assign fu_opb_o = w_gnt ? opb_i : '0;
  assign fu_tag_o = tag_i;
  assign fu_rnd_o = rnd_i;

  // A return with nothing outstanding is a protocol error; the counter holds
  // at zero rather than wrapping.
  assign w_stray_ret = fu_valid_i & (r_outstanding == '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_outstanding <= '0;
    end else if (w_gnt & ~fu_valid_i) begin
      r_outstanding <= r_outstanding + CNT_W'(1);
    end else if (~w_gnt & fu_valid_i & ~w_stray_ret) begin
      r_outstanding <= r_outstanding - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_err <= 1'b0;
    end else if (w_stray_ret | w_overflow) begin
      r_err <= 1'b1;
    end
  end

  assign w_rvalid = (w_count != '0);
  assign w_pop    = w_rvalid & rack_i;

  apu_res_fifo #(
    .DEPTH (RES_FIFO_DEPTH),
    .WIDTH (ENT_W)
  ) u_res_fifo (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .push_i     (fu_valid_i),
    .data_i     ({fu_res_i, fu_tag_i, fu_status_i}),
    .pop_i      (w_pop),
    .data_o     (w_head),
    .count_o    (w_count),
    .overflow_o (w_overflow)
  );

  assign rvalid_o                      = w_rvalid;
  assign {rdata_o, rtag_o, rstatus_o}  = w_head;
  assign busy_o                        = (r_outstanding != '0) | w_rvalid;
  assign err_o                         = r_err;

endmodule

// File: tb/tb_apu_fu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_apu_fu_issue_ctrl
// Randomized bench with a behavioural functional unit (in-order, variable
// latency) and a reference model tracking in-flight/buffered counts as plain
// integers. Expected results are queued at issue; a monitor pops and compares
// whenever the DUT hands a result to the core.
// ---------------------------------------------------------------------------
module tb_apu_fu_issue_ctrl;

  localparam int OPW   = 32;
  localparam int TW    = 5;
  localparam int RW    = 3;
  localparam int SW    = 5;
  localparam int DEPTH = 4;

  logic           clk_i       = 1'b0;
  logic           rst_ni      = 1'b0;
  logic           req_i       = 1'b0;
  logic           gnt_o;
  logic [OPW-1:0] opa_i       = '0;
  logic [OPW-1:0] opb_i       = '0;
  logic [TW-1:0]  tag_i       = '0;
  logic [RW-1:0]  rnd_i       = '0;
  logic           fu_en_o;
  logic [OPW-1:0] fu_opa_o;
  logic [OPW-1:0] fu_opb_o;
  logic [TW-1:0]  fu_tag_o;
  logic [RW-1:0]  fu_rnd_o;
  logic           fu_ready_i  = 1'b0;
  logic           fu_valid_i  = 1'b0;
  logic [OPW-1:0] fu_res_i    = '0;
  logic [TW-1:0]  fu_tag_i    = '0;
  logic [SW-1:0]  fu_status_i = '0;
  logic           rvalid_o;
  logic [OPW-1:0] rdata_o;
  logic [TW-1:0]  rtag_o;
  logic [SW-1:0]  rstatus_o;
  logic           rack_i      = 1'b0;
  logic           busy_o;
  logic           err_o;

  always #5 clk_i = ~clk_i;

  apu_fu_issue_ctrl #(
    .OP_WIDTH       (OPW),
    .TAG_WIDTH      (TW),
    .RND_WIDTH      (RW),
    .STAT_WIDTH     (SW),
    .RES_FIFO_DEPTH (DEPTH)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_i       (req_i),
    .gnt_o       (gnt_o),
    .opa_i       (opa_i),
    .opb_i       (opb_i),
    .tag_i       (tag_i),
    .rnd_i       (rnd_i),
    .fu_en_o     (fu_en_o),
    .fu_opa_o    (fu_opa_o),
    .fu_opb_o    (fu_opb_o),
    .fu_tag_o    (fu_tag_o),
    .fu_rnd_o    (fu_rnd_o),
    .fu_ready_i  (fu_ready_i),
    .fu_valid_i  (fu_valid_i),
    .fu_res_i    (fu_res_i),
    .fu_tag_i    (fu_tag_i),
    .fu_status_i (fu_status_i),
    .rvalid_o    (rvalid_o),
    .rdata_o     (rdata_o),
    .rtag_o      (rtag_o),
    .rstatus_o   (rstatus_o),
    .rack_i      (rack_i),
    .busy_o      (busy_o),
    .err_o       (err_o)
  );

  typedef struct {
    logic [OPW-1:0] res;
    logic [TW-1:0]  tag;
    logic [SW-1:0]  status;
    int             ready;
  } op_t;

  op_t unit_q[$];  // operations inside the behavioural unit
  op_t exp_q[$];   // scoreboard: results the core should receive, in order

  int  n_checks = 0;
  int  n_fail   = 0;
  int  cyc      = 0;
  int  m_out    = 0;   // model: issued, not yet returned
  int  m_cnt    = 0;   // model: results buffered
  bit  m_err    = 1'b0;
  int  last_ready = 0;
  int  dut_grants = 0;
  int  n_pops     = 0;
  logic [OPW-1:0] last_pop_res = '0;

  int req_pct = 0, rack_pct = 0, ready_pct = 100, lat_min = 1, lat_max = 1;
  bit use_fixed = 1'b0;
  logic [OPW-1:0] fix_a = '0, fix_b = '0;
  logic [TW-1:0]  tag_ctr = '0;
  bit  inj_pending = 1'b0;
  op_t inj;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural unit: 1.0 * b is exact; other operands use a mixing function.
  function automatic logic [OPW-1:0] unit_res(input logic [OPW-1:0] a, input logic [OPW-1:0] b);
    if (a == 32'h3F80_0000) return b;
    return a ^ {b[15:0], b[31:16]};
  endfunction

  function automatic logic [SW-1:0] unit_stat(input logic [OPW-1:0] a, input logic [RW-1:0] rnd);
    return {a[1:0], rnd};
  endfunction

  task automatic step();
    bit  p_gnt, pop, accepted, inj_now;
    op_t op;
    int  lat;
    @(posedge clk_i);
    #1;
    cyc++;
    inj_now     = 1'b0;
    req_i       = ($urandom_range(99) < req_pct);
    opa_i       = use_fixed ? fix_a : $urandom();
    opb_i       = use_fixed ? fix_b : $urandom();
    tag_i       = tag_ctr;
    rnd_i       = RW'($urandom_range(7));
    fu_ready_i  = ($urandom_range(99) < ready_pct);
    rack_i      = ($urandom_range(99) < rack_pct);
    fu_valid_i  = 1'b0;
    fu_res_i    = $urandom();
    fu_tag_i    = TW'($urandom());
    fu_status_i = SW'($urandom());
    if (inj_pending && unit_q.size() == 0) begin
      fu_valid_i  = 1'b1;
      fu_res_i    = inj.res;
      fu_tag_i    = inj.tag;
      fu_status_i = inj.status;
      inj_pending = 1'b0;
      inj_now     = 1'b1;
    end else if (unit_q.size() != 0 && unit_q[0].ready <= cyc) begin
      fu_valid_i  = 1'b1;
      fu_res_i    = unit_q[0].res;
      fu_tag_i    = unit_q[0].tag;
      fu_status_i = unit_q[0].status;
      void'(unit_q.pop_front());
    end
    @(negedge clk_i);
    p_gnt = req_i && fu_ready_i && (m_out + m_cnt < DEPTH);
    check("gnt", gnt_o, p_gnt);
    check("fu_en", fu_en_o, p_gnt);
    check("fu_opa", fu_opa_o, p_gnt ? opa_i : '0);
    check("fu_opb", fu_opb_o, p_gnt ? opb_i : '0);
    check("fu_tag", fu_tag_o, tag_i);
    check("fu_rnd", fu_rnd_o, rnd_i);
    check("rvalid", rvalid_o, m_cnt != 0);
    check("busy", busy_o, (m_out != 0) || (m_cnt != 0));
    check("err", err_o, m_err);
    if (m_cnt == 0)
      check("head_empty", {rdata_o, rtag_o, rstatus_o}, '0);
    else if (exp_q.size() != 0)
      check("head", {rdata_o, rtag_o, rstatus_o}, {exp_q[0].res, exp_q[0].tag, exp_q[0].status});
    if (gnt_o) dut_grants++;

    pop      = (m_cnt != 0) && rack_i;
    accepted = 1'b0;
    if (fu_valid_i) begin
      if (m_out == 0) m_err = 1'b1;
      if (m_cnt == DEPTH && !pop) m_err = 1'b1;
      else                        accepted = 1'b1;
    end
    if (inj_now && accepted) exp_q.push_back(inj);
    if (p_gnt) begin
      op.res    = unit_res(opa_i, opb_i);
      op.tag    = tag_i;
      op.status = unit_stat(opa_i, rnd_i);
      lat       = int'($urandom_range(lat_max, lat_min));
      op.ready  = cyc + lat;
      if (op.ready <= last_ready) op.ready = last_ready + 1;
      last_ready = op.ready;
      unit_q.push_back(op);
      exp_q.push_back(op);
      tag_ctr++;
    end
    if (p_gnt && !fu_valid_i)                    m_out++;
    else if (!p_gnt && fu_valid_i && m_out > 0)  m_out--;
    m_cnt = m_cnt + (accepted ? 1 : 0) - (pop ? 1 : 0);
  endtask

  // Monitor: one line per result handed to the core.
  initial begin
    op_t e;
    forever begin
      @(negedge clk_i);
      #1;
      if (rst_ni && rvalid_o && rack_i) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL pop_unexpected: got tag %0d data %08h, expected no result", rtag_o, rdata_o);
        end else begin
          e = exp_q.pop_front();
          check("pop_data", rdata_o, e.res);
          check("pop_tag", rtag_o, e.tag);
          check("pop_status", rstatus_o, e.status);
          last_pop_res = rdata_o;
          n_pops++;
          $display("result cycle=%0d tag=%0d data=%08h status=%02h", cyc, rtag_o, rdata_o, rstatus_o);
        end
      end
    end
  end

  task automatic do_reset();
    #2;
    rst_ni = 1'b0;
    req_i = 1'b0; fu_valid_i = 1'b0; rack_i = 1'b0; fu_ready_i = 1'b0;
    opa_i = '0; opb_i = '0; tag_i = '0; rnd_i = '0;
    #1;
    check("rst_gnt", gnt_o, 0);
    check("rst_fu_en", fu_en_o, 0);
    check("rst_fu_ops", {fu_opa_o, fu_opb_o}, '0);
    check("rst_rvalid", rvalid_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_err", err_o, 0);
    check("rst_rdata", {rdata_o, rtag_o, rstatus_o}, '0);
    unit_q.delete();
    exp_q.delete();
    m_out = 0; m_cnt = 0; m_err = 1'b0;
    last_ready = 0; tag_ctr = '0; inj_pending = 1'b0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic drain();
    int n;
    req_pct = 0; rack_pct = 100; ready_pct = 100;
    n = 0;
    while ((m_out != 0 || m_cnt != 0 || unit_q.size() != 0) && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d in flight, %0d buffered, expected 0 and 0", m_out, m_cnt);
    end
    step();
  endtask

  initial begin
    int n, pops0;
    do_reset();

    // Single operation, latency 2.
    use_fixed = 1'b1; fix_a = 32'h3F80_0000; fix_b = 32'h4000_0000;
    tag_ctr = 5'd3; lat_min = 2; lat_max = 2;
    req_pct = 100; ready_pct = 100; rack_pct = 100;
    dut_grants = 0;
    step();
    check("single_grants", dut_grants, 1);
    req_pct = 0;
    repeat (6) step();
    check("single_res", last_pop_res, 32'h4000_0000);
    check("single_idle", busy_o, 0);
    use_fixed = 1'b0;

    // Credit stall: no acks, requests held high.
    tag_ctr = '0; lat_min = 1; lat_max = 4;
    req_pct = 100; rack_pct = 0; dut_grants = 0;
    repeat (12) step();
    check("stall_grants", dut_grants, 4);
    check("stall_err", err_o, 0);
    drain();

    // Full-rate streaming at latency 2.
    lat_min = 2; lat_max = 2; req_pct = 100; rack_pct = 100; dut_grants = 0;
    repeat (20) step();
    check("stream2_grants", dut_grants, 20);
    drain();

    // Streaming 20 operations at latency 3.
    lat_min = 3; lat_max = 3; dut_grants = 0; pops0 = n_pops; n = 0;
    req_pct = 100; rack_pct = 100;
    while (dut_grants < 20 && n < 100) begin step(); n++; end
    req_pct = 0;
    drain();
    check("stream3_results", n_pops - pops0, 20);
    check("stream3_err", err_o, 0);

    // Random mix: issue/return and push/pop collisions.
    req_pct = 70; rack_pct = 50; ready_pct = 80; lat_min = 1; lat_max = 5;
    repeat (300) step();
    drain();

    // Stray return with nothing outstanding, then sticky for 100 cycles.
    inj.res = 32'hDEAD_BEEF; inj.tag = 5'h1F; inj.status = 5'h15; inj.ready = 0;
    req_pct = 0; rack_pct = 0; inj_pending = 1'b1;
    step();
    req_pct = 50; rack_pct = 50; ready_pct = 100;
    repeat (100) step();
    drain();

    // Full FIFO: a return without pop is dropped, one with pop is kept.
    req_pct = 100; rack_pct = 0; lat_min = 1; lat_max = 2;
    repeat (10) step();
    req_pct = 0; inj.res = 32'h1234_5678; inj_pending = 1'b1;
    step();
    rack_pct = 100; inj.res = 32'h8765_4321; inj_pending = 1'b1;
    step();
    drain();
    check("err_sticky", err_o, 1);
    do_reset();

    // Reset with two in flight and two buffered.
    req_pct = 100; rack_pct = 0; ready_pct = 100; lat_min = 3; lat_max = 3; n = 0;
    while (!(m_out == 2 && m_cnt == 2) && n < 20) begin step(); n++; end
    if (n >= 20) begin
      n_checks++;
      n_fail++;
      $display("FAIL midreset_setup: got %0d in flight, %0d buffered, expected 2 and 2", m_out, m_cnt);
    end
    do_reset();
    dut_grants = 0;
    step();
    check("post_reset_gnt", dut_grants, 1);
    drain();
    check("leftover_results", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
